// File: rtl/mult_share_pkg.sv
// Shared types and sizing for the time-multiplexed shift-add multiplier.
// Optional zero-operand bypass is enabled by defining MULT_SHARE_ZERO_SKIP_EN.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int STEPS  = 4;
    localparam int CNT_W  = $clog2(STEPS);

endpackage

// File: rtl/mult_rr_grant.sv
// Two-requester round-robin grant; the pointer names the requester that wins a tie.
module mult_rr_grant #(
    parameter int RR_START = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    logic ptr;

    // A grant always coincides with its valid, so a grant is also an accept.
    always_comb begin
        grant0 = enable & valid0 & (~valid1 | ~ptr);
        grant1 = enable & valid1 & (~valid0 | ptr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= (RR_START != 0);
        end else if (grant0) begin
            ptr <= 1'b1;
        end else if (grant1) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Two requesters share one 4x4 shift-add multiplier, one transaction at a time.
// Define MULT_SHARE_ZERO_SKIP_EN to finish zero-operand requests without the CALC pass.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int RR_START = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_product,
    output logic              rsp_src
);

    state_t              state;
    logic                grant0;
    logic                grant1;
    logic                accept;
    logic                zero_op;
    logic [OP_W-1:0]     sel_a;
    logic [OP_W-1:0]     sel_b;
    logic [OP_W-1:0]     a_reg;
    logic [OP_W-1:0]     b_reg;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   partial;
    logic [CNT_W-1:0]    cnt;

    mult_rr_grant #(
        .RR_START(RR_START)
    ) u_grant (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (rst_n && (state == IDLE)),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign sel_a      = grant1 ? req1_a : req0_a;
    assign sel_b      = grant1 ? req1_b : req0_b;
    assign partial    = b_reg[cnt] ? (PROD_W'(a_reg) << cnt) : '0;
    assign rsp_product = rsp_valid ? acc : '0;

`ifdef MULT_SHARE_ZERO_SKIP_EN
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // One partial product per CALC edge; the result is presented once all bits of b are consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_src   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg   <= sel_a;
                        b_reg   <= sel_b;
                        rsp_src <= grant1;
                        acc     <= '0;
                        cnt     <= '0;
                        if (zero_op) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc + partial;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
